// File: rtl/cpu_defs_pkg.sv
// Shared CPU register-file constants and slice helpers for flattened multi-port vectors.
`ifndef CPU_DEFS_MACROS
`define CPU_DEFS_MACROS
`define CPU_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package cpu_defs;
    localparam int CPU_DW    = 32;
    localparam int CPU_DEPTH = 32;
    localparam int REG_ZERO  = 0;
endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_mp_sb
    import cpu_defs::*;
#(
    parameter int DEPTH    = CPU_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        busy_nxt = busy;
        for (int n = 0; n < DEPTH; n++) begin
            if ((we0 && wa0 == AW'(n)) || (we1 && wa1 == AW'(n)))
                busy_nxt[n] = 1'b0;
            // Set is evaluated last: a new producer issued as the old one retires keeps the bit.
            if (sb_set && sb_addr == AW'(n))
                busy_nxt[n] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers of busy.
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with pending-write scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
    import cpu_defs::*;
#(
    parameter int DW       = CPU_DW,
    parameter int DEPTH    = CPU_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DW-1:0] mem [DEPTH];
    logic          wr_ok0;
    logic          wr_ok1;

    assign wr_ok0 = we0 && !(ZERO_REG != 0 && wa0 == AW'(REG_ZERO));
    assign wr_ok1 = we1 && !(ZERO_REG != 0 && wa1 == AW'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: a full synchronous clear of the array forces flops rather than a RAM macro; required here because every register must read 0 after reset.
            for (int n = 0; n < DEPTH; n++)
                mem[n] <= '0;
        end else begin
            if (wr_ok0)
                mem[wa0] <= wd0;
            // Port 1 is scheduled last so it wins when both ports hit the same address.
            if (wr_ok1)
                mem[wa1] <= wd1;
        end
    end

    regfile_mp_sb #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .busy_vec (busy_vec)
    );

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            logic [AW-1:0] addr;
            logic [DW-1:0] data;
            logic          busy;
            addr = `CPU_FIELD(ra, i, AW);
            data = mem[addr];
            busy = busy_vec[addr];
`ifdef REGFILE_MP_BYPASS_EN
            if (we1 && wa1 == addr)
                data = wd1;
            else if (we0 && wa0 == addr)
                data = wd0;
            if (((we1 && wa1 == addr) || (we0 && wa0 == addr)) && !(sb_set && sb_addr == addr))
                busy = 1'b0;
`endif
            if (ZERO_REG != 0 && addr == AW'(REG_ZERO))
                data = '0;
            `CPU_FIELD(rd, i, DW) = data;
            rbusy[i] = busy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32/2-port instance plus a 16x16/4-port instance.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_VEC  = 2;
    localparam int K_RD4  = 3;
    localparam int K_BSY4 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: defaults (DW=32, DEPTH=32, NR=2)
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic [1:0]  rbusy_a;
    logic        we0_a, we1_a, sb_set_a;
    logic [4:0]  wa0_a, wa1_a, sb_addr_a;
    logic [31:0] wd0_a, wd1_a;
    logic [31:0] busy_vec_a;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
        .we0(we0_a), .wa0(wa0_a), .wd0(wd0_a),
        .we1(we1_a), .wa1(wa1_a), .wd1(wd1_a),
        .sb_set(sb_set_a), .sb_addr(sb_addr_a), .busy_vec(busy_vec_a)
    );

    // Instance B: NR=4, DEPTH=16, DW=16
    logic [15:0] ra_b;
    logic [63:0] rd_b;
    logic [3:0]  rbusy_b;
    logic        we0_b, we1_b, sb_set_b;
    logic [3:0]  wa0_b, wa1_b, sb_addr_b;
    logic [15:0] wd0_b, wd1_b;
    logic [15:0] busy_vec_b;

    regfile_mp #(.DW(16), .DEPTH(16), .NR(4)) dut_b (
        .clk(clk), .rst(rst), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
        .we0(we0_b), .wa0(wa0_b), .wd0(wd0_b),
        .we1(we1_b), .wa1(wa1_b), .wd1(wd1_b),
        .sb_set(sb_set_b), .sb_addr(sb_addr_b), .busy_vec(busy_vec_b)
    );

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_val(input int kind, input int idx, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every expectation queued for a cycle is settled by the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                K_RD:    act = rd_a[e.idx*32 +: 32];
                K_BUSY:  act = {31'b0, rbusy_a[e.idx]};
                K_VEC:   act = busy_vec_a;
                K_RD4:   act = {16'b0, rd_b[e.idx*16 +: 16]};
                K_BSY4:  act = {16'b0, busy_vec_b};
                default: act = 'x;
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0_a = 0; we1_a = 0; sb_set_a = 0;
        we0_b = 0; we1_b = 0; sb_set_b = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ra_a = '0; wa0_a = '0; wa1_a = '0; wd0_a = '0; wd1_a = '0; sb_addr_a = '0;
        ra_b = '0; wa0_b = '0; wa1_b = '0; wd0_b = '0; wd1_b = '0; sb_addr_b = '0;
        idle();
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        ra_a[4:0] = 5; ra_a[9:5] = 31;
        expect_val(K_RD,   0, 32'h0, "rst_rd0_a5");
        expect_val(K_RD,   1, 32'h0, "rst_rd1_a31");
        expect_val(K_BUSY, 0, 32'h0, "rst_busy0");
        expect_val(K_BUSY, 1, 32'h0, "rst_busy1");
        expect_val(K_VEC,  0, 32'h0, "rst_vec");
        expect_val(K_BSY4, 0, 32'h0, "rst_vec_b");
        cyc();

        // Single write, same-cycle read
        idle(); we0_a = 1; wa0_a = 3; wd0_a = 32'hDEADBEEF; ra_a[4:0] = 3;
        expect_val(K_RD, 0, BYP ? 32'hDEADBEEF : 32'h0, "wr3_same_cycle");
        cyc();
        idle();
        expect_val(K_RD, 0, 32'hDEADBEEF, "wr3_next_cycle");
        cyc();

        // Both ports to addr 7: port 1 wins
        idle(); we0_a = 1; wa0_a = 7; wd0_a = 32'h11; we1_a = 1; wa1_a = 7; wd1_a = 32'h22;
        ra_a[4:0] = 7;
        expect_val(K_RD, 0, BYP ? 32'h22 : 32'h0, "dual_wr7_same_cycle");
        cyc();
        idle(); we0_a = 1; wa0_a = 0; wd0_a = 32'hFFFF_FFFF; ra_a[9:5] = 0;
        expect_val(K_RD, 0, 32'h22, "dual_wr7_prio");
        expect_val(K_RD, 1, 32'h0, "zero_wr_same_cycle");
        cyc();
        idle();
        expect_val(K_RD, 1, 32'h0, "zero_wr_ignored");
        cyc();

        // Scoreboard set / clear / set-wins
        idle(); sb_set_a = 1; sb_addr_a = 9; ra_a[4:0] = 9;
        expect_val(K_BUSY, 0, 32'h0, "sb9_not_yet");
        cyc();
        idle(); we1_a = 1; wa1_a = 9; wd1_a = 32'h99;
        expect_val(K_VEC,  0, 32'h0000_0200, "sb9_vec");
        expect_val(K_BUSY, 0, BYP ? 32'h0 : 32'h1, "sb9_busy_wb_cycle");
        expect_val(K_RD,   0, BYP ? 32'h99 : 32'h0, "wb9_same_cycle");
        cyc();
        idle(); sb_set_a = 1; sb_addr_a = 9; we0_a = 1; wa0_a = 9; wd0_a = 32'hAA;
        expect_val(K_BUSY, 0, 32'h0, "sb9_cleared");
        expect_val(K_VEC,  0, 32'h0, "sb9_vec_cleared");
        expect_val(K_RD,   0, BYP ? 32'hAA : 32'h99, "wb9_data");
        cyc();
        idle(); sb_set_a = 1; sb_addr_a = 0;
        expect_val(K_BUSY, 0, 32'h1, "sb9_set_wins");
        expect_val(K_RD,   0, 32'hAA, "wb9_data2");
        cyc();
        idle(); sb_set_a = 1; sb_addr_a = 9;
        expect_val(K_VEC,  0, 32'h0000_0200, "sb0_ignored");
        expect_val(K_BUSY, 1, 32'h0, "sb0_busy");
        cyc();
        idle(); we0_a = 1; wa0_a = 12; wd0_a = 32'h55; ra_a[4:0] = 12;
        expect_val(K_VEC, 0, 32'h0000_0200, "sb9_reset_idempotent");
        cyc();
        idle(); sb_set_a = 1; sb_addr_a = 12;
        expect_val(K_RD, 0, 32'h55, "wr12");
        cyc();
        idle();
        expect_val(K_VEC,  0, 32'h0000_1200, "sb12_vec");
        expect_val(K_BUSY, 0, 32'h1, "sb12_busy");
        cyc();

        // Reset mid-operation, with a write and sb_set presented in the reset cycle
        rst = 1'b1; we1_a = 1; wa1_a = 12; wd1_a = 32'h77; sb_set_a = 1; sb_addr_a = 20;
        cyc();
        rst = 1'b0; idle(); ra_a[9:5] = 20;
        expect_val(K_RD,   0, 32'h0, "post_rst_rd12");
        expect_val(K_BUSY, 0, 32'h0, "post_rst_busy12");
        expect_val(K_BUSY, 1, 32'h0, "post_rst_busy20");
        expect_val(K_VEC,  0, 32'h0, "post_rst_vec");
        expect_val(K_RD,   1, 32'h0, "post_rst_rd20");
        cyc();

        // Four-port instance
        idle(); we0_b = 1; wa0_b = 1; wd0_b = 16'h1111; we1_b = 1; wa1_b = 2; wd1_b = 16'h2222;
        cyc();
        idle(); we0_b = 1; wa0_b = 3; wd0_b = 16'h3333; we1_b = 1; wa1_b = 4; wd1_b = 16'h4444;
        cyc();
        idle(); ra_b = {4'd1, 4'd2, 4'd3, 4'd4};
        expect_val(K_RD4, 0, 32'h4444, "nr4_port0");
        expect_val(K_RD4, 1, 32'h3333, "nr4_port1");
        expect_val(K_RD4, 2, 32'h2222, "nr4_port2");
        expect_val(K_RD4, 3, 32'h1111, "nr4_port3");
        cyc();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file.
- Configurable data width, depth and read-port count.
- Two write ports with fixed priority and optional hard-wired zero register.
- Synchronous clear of all registers.
- Per-register pending-write scoreboard used by the decode stage to detect RAW hazards in the pipeline.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥ 2.
- AW, $clog2(DEPTH), address width; derived, do not override.
- NR, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 means register 0 reads as 0 and ignores writes and scoreboard sets.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- ra  in  NR*AW  read addresses; port i at bits [i*AW +: AW].
- rd  out  NR*DW  read data; port i at bits [i*DW +: DW].
- rbusy  out  NR  port i's register has a pending write.
- we0  in  1  write enable, port 0 (low priority).
- wa0  in  AW  write address, port 0.
- wd0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (high priority).
- wa1  in  AW  write address, port 1.
- wd1  in  DW  write data, port 1.
- sb_set  in  1  mark sb_addr pending (instruction issued with destination sb_addr).
- sb_addr  in  AW  scoreboard set address.
- busy_vec  out  DEPTH  raw scoreboard bits, bit n = register n pending.

Behaviour:
- Single clock domain clk. Reset is synchronous and active-high on rst, sampled at the rising edge.

Reset:
- While rst is high at a clock edge, all DEPTH registers become 0 and all scoreboard bits become 0.
- Writes and sb_set in that cycle are ignored.
- After reset: rd = 0 on every port, rbusy = 0, busy_vec = 0.
- Reset mid-operation discards pending writes; no state survives.

Writes:
- Registered at posedge clk; a read of that register reflects the new data from the next cycle.
- we0 and we1 to different addresses: both commit in the same edge.
- we0 and we1 to the same address: wd1 commits, wd0 is dropped.
- ZERO_REG=1 and address 0: write ignored.

Reads:
- Combinational, zero latency: rd[i] = rf[ra[i]].
- ZERO_REG=1 and ra[i]=0: rd[i] = 0 regardless of storage.
- rbusy[i] = busy_vec[ra[i]].

Scoreboard (one bit per register):
- Set on edge when sb_set=1, subject to the ZERO_REG=1 / sb_addr=0 exception below.
- Cleared on edge when we0 or we1 targets that register (writeback commit).
- Set and clear of the same register in the same cycle: set wins; a new producer was issued as the old one retires.
- sb_set to an already-busy register: stays 1. No counting; the pipeline guarantees in-order writeback per register.
- ZERO_REG=1: bit 0 is constant 0.
- Write to a non-busy register is legal; the bit stays 0.

Optional Feature:
- Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If we1 && wa1==ra[i], rd[i]=wd1.
  - Else if we0 && wa0==ra[i], rd[i]=wd0.
  - Else storage.
  - ZERO_REG masking is applied after forwarding.
  - rbusy[i] is also forced to 0 when a same-cycle write targets ra[i] and sb_set does not target it.
  - Removes the half-cycle write/read split needed by the pipeline.
- Undefined: rd and rbusy reflect storage and scoreboard state only; same-cycle writes become visible next cycle.

Decomposition:
- Shared package/header cpu_defs holds:
  - DW/DEPTH defaults;
  - REG_ZERO index constant;
  - field-slice helper macros for flattened port vectors.
- One natural sub-module, regfile_mp_sb: the DEPTH-bit scoreboard with its set/clear priority and ZERO_REG masking. It is instantiated once.
- Read muxing and write storage stay in the top.

Test Plan:
- Reset, then read ports 0/1 at addr 5 and 31: rd=0, rbusy=0, busy_vec=0.
- we0 wa0=3 wd0=0xDEADBEEF, next cycle ra[0]=3: rd[0]=0xDEADBEEF. Same cycle with bypass off: old value 0. Same cycle with bypass on: 0xDEADBEEF.
- we0 and we1 both to addr 7 (wd0=0x11, wd1=0x22): next cycle rd=0x22. we0 to addr 0 with wd0=0xFFFF_FFFF and ZERO_REG=1: rd at addr 0 = 0.
- sb_set addr 9: rbusy for ra=9 is 1 next cycle. we1 wa1=9 clears it the following cycle. sb_set 9 together with we0 wa0=9 in one cycle: bit stays 1.
- Write 0x55 to addr 12, sb_set 12, then assert rst one cycle: rd(12)=0 and busy_vec=0 after the reset edge. A write presented during the reset cycle is not stored.
- NR=4, DEPTH=16, DW=16 instance: four distinct simultaneous reads return four independently written values (0x1111, 0x2222, 0x3333, 0x4444).
